// File: rtl/ecp5pll_pkg.sv
// ecp5pll_pkg
//   Shared definitions for the ECP5 PLL wrapper family:
//   - state_t      : sequencer states of the dynamic phase-shift controller
//   - *_KHZ        : PFD / VCO operating limits used by the ecp5pll generator
//   - phase_mod()  : fine-phase modulus (in steps) of an output from its divider
package ecp5pll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STEP_HI = 3'd2,
        ST_STEP_LO = 3'd3,
        ST_LOAD_HI = 3'd4,
        ST_LOAD_LO = 3'd5,
        ST_FIN     = 3'd6
    } state_t;

    localparam int unsigned PFD_MIN_KHZ = 3125;
    localparam int unsigned PFD_MAX_KHZ = 400000;
    localparam int unsigned VCO_MIN_KHZ = 400000;
    localparam int unsigned VCO_MAX_KHZ = 800000;

    // One phasestep moves an output by 1/8 of a VCO period, so an output
    // divided by N wraps after 8*N steps.
    localparam int unsigned PHASE_STEPS_PER_DIV = 8;

    function automatic int unsigned phase_mod(input int unsigned odiv);
        return PHASE_STEPS_PER_DIV * odiv;
    endfunction

endpackage

// File: rtl/phase_wrap_cnt.sv
// phase_wrap_cnt
//   Modulo-MOD up/down counter tracking one PLL output's fine-phase offset.
//   Ports:
//     clk_i    in   system clock
//     reset_n  in   asynchronous active-low reset (count -> 0)
//     inc_i    in   +1 step, wraps MOD-1 -> 0
//     dec_i    in   -1 step, wraps 0 -> MOD-1
//     clr_i    in   force count to 0 (static phase reload); wins over inc/dec
//     cnt_o    out  current offset, 0..MOD-1
module phase_wrap_cnt
    import ecp5pll_pkg::*;
#(
    parameter int CNT_W = 10,
    parameter int MOD   = 8
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(MOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wrap by comparison against MOD-1 rather than a modulo operator.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == MAX) ? '0 : cnt_q + CNT_W'(1);
        end else if (dec_i) begin
            cnt_d = (cnt_q == '0) ? MAX : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl
//   Sequencer for the ECP5 PLL dynamic phase-shift port. Accepts step or
//   reload requests over valid/ready, holds phasesel/phasedir for a setup
//   time, emits registered phasestep / phaseloadreg pulses and tracks each
//   output's phase offset modulo its period. Lock loss aborts the request.
//   Ports:
//     clk_i, reset_n    clock, asynchronous active-low reset
//     locked_i          PLL lock
//     req_valid/ready   request handshake (ready only in IDLE while locked)
//     req_load          1 = static phase reload, 0 = step request
//     req_sel           output index 0..3
//     req_dir           0 = +1 step (lag), 1 = -1 step (lead)
//     req_steps         step count (0 legal)
//     done / err        one-cycle completion / lock-loss abort pulse
//     busy              request in progress
//     phasesel, phasedir, phasestep, phaseloadreg   to ecp5pll
//     phase_o           tracked offsets, output n at [n*CNT_W +: CNT_W]
module ecp5pll_phase_ctrl
    import ecp5pll_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int STEP_HI_CYC = 2,
    parameter int STEP_LO_CYC = 2,
    parameter int CNT_W       = 10,
    parameter int MOD0        = phase_mod(1),
    parameter int MOD1        = phase_mod(1),
    parameter int MOD2        = phase_mod(1),
    parameter int MOD3        = phase_mod(1)
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               locked_i,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_load,
    input  logic [1:0]         req_sel,
    input  logic               req_dir,
    input  logic [CNT_W-1:0]   req_steps,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg,
    output logic [4*CNT_W-1:0] phase_o
);

    localparam int TIM_W = 16;
    localparam int MODS [4] = '{MOD0, MOD1, MOD2, MOD3};

    state_t             state_q, state_d;
    logic [TIM_W-1:0]   tim_q, tim_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic               load_q, load_d;
    logic               abort_q, abort_d;
    logic               step_q, step_d;
    logic               ldreg_q, ldreg_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               abort_now;
    logic               tim_zero;
    logic               step_end;
    logic               load_end;

    // Duration of a timed state, stored as cycles-1 so the state ends on tim_q==0.
    function automatic logic [TIM_W-1:0] state_dur(input state_t s);
        case (s)
            ST_SETUP:               return TIM_W'(SETUP_CYC - 1);
            ST_STEP_HI, ST_LOAD_HI: return TIM_W'(STEP_HI_CYC - 1);
            ST_STEP_LO, ST_LOAD_LO: return TIM_W'(STEP_LO_CYC - 1);
            default:                return '0;
        endcase
    endfunction

    assign req_ready = reset_n && (state_q == ST_IDLE) && locked_i;
    assign accept    = req_valid && req_ready;
    // Lock loss is sticky for the rest of the request.
    assign abort_now = abort_q || !locked_i;
    assign tim_zero  = (tim_q == '0);
    assign step_end  = (state_q == ST_STEP_HI) && tim_zero;
    assign load_end  = (state_q == ST_LOAD_HI) && tim_zero;

    // State register
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tim_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            load_q  <= 1'b0;
            abort_q <= 1'b0;
            step_q  <= 1'b0;
            ldreg_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tim_q   <= tim_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            load_q  <= load_d;
            abort_q <= abort_d;
            step_q  <= step_d;
            ldreg_q <= ldreg_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. High pulses always run to full width; lock loss is
    // acted on at the end of a high pulse or immediately in other states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (abort_now)          state_d = ST_FIN;
                else if (tim_zero) begin
                    if (load_q)         state_d = ST_LOAD_HI;
                    else if (rem_q == '0) state_d = ST_FIN;
                    else                state_d = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                if (tim_zero) state_d = abort_now ? ST_FIN : ST_STEP_LO;
            end
            ST_STEP_LO: begin
                if (abort_now)          state_d = ST_FIN;
                else if (tim_zero)      state_d = (rem_q == '0) ? ST_FIN : ST_STEP_HI;
            end
            ST_LOAD_HI: begin
                if (tim_zero) state_d = abort_now ? ST_FIN : ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                if (abort_now || tim_zero) state_d = ST_FIN;
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; strobes are registered from state_d so
    // they change only on the clock edge.
    always_comb begin
        sel_d   = sel_q;
        dir_d   = dir_q;
        load_d  = load_q;
        rem_d   = rem_q;
        abort_d = 1'b0;
        tim_d   = '0;

        if (accept) begin
            sel_d  = req_sel;
            dir_d  = req_dir;
            load_d = req_load;
            rem_d  = req_steps;
        end else if (step_end) begin
            rem_d  = rem_q - CNT_W'(1);
        end

        if (state_q != ST_IDLE) abort_d = abort_now;

        if (state_d != state_q) tim_d = state_dur(state_d);
        else if (!tim_zero)     tim_d = tim_q - TIM_W'(1);

        step_d  = (state_d == ST_STEP_HI);
        ldreg_d = (state_d == ST_LOAD_HI);
        done_d  = (state_d == ST_FIN) && (state_q != ST_FIN) && !abort_now;
        err_d   = (state_d == ST_FIN) && (state_q != ST_FIN) && abort_now;
    end

    for (genvar g = 0; g < 4; g++) begin : g_phase
        phase_wrap_cnt #(
            .CNT_W (CNT_W),
            .MOD   (MODS[g])
        ) u_cnt (
            .clk_i   (clk_i),
            .reset_n (reset_n),
            .inc_i   (step_end && (sel_q == 2'(g)) && !dir_q),
            .dec_i   (step_end && (sel_q == 2'(g)) && dir_q),
            .clr_i   (load_end && (sel_q == 2'(g))),
            .cnt_o   (phase_o[g*CNT_W +: CNT_W])
        );
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = step_q;
    assign phaseloadreg = ldreg_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed bench for ecp5pll_phase_ctrl with default parameters (all MODn = 8).
// Cycle 0 is the cycle in which a request is presented and accepted.
module tb_ecp5pll_phase_ctrl;

    localparam int CNT_W = 10;

    logic               clk_i = 1'b0;
    logic               reset_n;
    logic               locked_i;
    logic               req_valid;
    logic               req_ready;
    logic               req_load;
    logic [1:0]         req_sel;
    logic               req_dir;
    logic [CNT_W-1:0]   req_steps;
    logic               done;
    logic               err;
    logic               busy;
    logic [1:0]         phasesel;
    logic               phasedir;
    logic               phasestep;
    logic               phaseloadreg;
    logic [4*CNT_W-1:0] phase_o;

    int checks = 0;
    int errors = 0;

    int   cyc, first_rise, done_cyc, err_cyc, pulses, lpulses;
    int   hi_run, lo_run, hi_bad, lo_bad, both_hi;
    logic prev_step, prev_load;
    logic [1:0] sel_at1;
    logic dir_at1, busy_at1, ready_at1;

    ecp5pll_phase_ctrl dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .locked_i     (locked_i),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_load     (req_load),
        .req_sel      (req_sel),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .phasesel     (phasesel),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg),
        .phase_o      (phase_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] ph(input int n);
        return phase_o[n*CNT_W +: CNT_W];
    endfunction

    // Present one request in the current cycle (cycle 0) and follow it until
    // done or err, logging pulse timing. Leaves the bench in the cycle after.
    task automatic run_req(input logic ld, input logic [1:0] sel, input logic dr,
                           input logic [CNT_W-1:0] n, input int drop_at);
        req_valid = 1'b1; req_load = ld; req_sel = sel; req_dir = dr; req_steps = n;
        tick();
        req_valid = 1'b0; req_load = 1'b0;
        cyc = 1;
        sel_at1 = phasesel; dir_at1 = phasedir; busy_at1 = busy; ready_at1 = req_ready;
        first_rise = -1; done_cyc = -1; err_cyc = -1; pulses = 0; lpulses = 0;
        hi_run = 0; lo_run = 0; hi_bad = 0; lo_bad = 0; both_hi = 0;
        prev_step = 1'b0; prev_load = 1'b0;
        while (cyc < 200 && done_cyc < 0 && err_cyc < 0) begin
            if (cyc == drop_at) locked_i = 1'b0;
            if (phasestep && phaseloadreg) both_hi++;
            if (phasestep && !prev_step) begin
                if (pulses > 0 && lo_run != 2) lo_bad++;
                if (first_rise < 0) first_rise = cyc;
                pulses++;
                hi_run = 1;
            end else if (phasestep) begin
                hi_run++;
            end
            if (!phasestep && prev_step) begin
                if (hi_run != 2) hi_bad++;
                lo_run = 1;
            end else if (!phasestep) begin
                lo_run++;
            end
            if (phaseloadreg && !prev_load) lpulses++;
            if (done) done_cyc = cyc;
            if (err)  err_cyc = cyc;
            prev_step = phasestep;
            prev_load = phaseloadreg;
            tick();
            cyc++;
        end
    endtask

    initial begin
        reset_n = 1'b0; locked_i = 1'b1; req_valid = 1'b0; req_load = 1'b0;
        req_sel = 2'd0; req_dir = 1'b0; req_steps = '0;

        // Reset state
        tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step", phasestep, 0);
        chk("rst_phase", phase_o, 0);
        chk("rst_done", {done, err, phaseloadreg}, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_ready", req_ready, 1);

        // sel=1, +3 steps
        run_req(1'b0, 2'd1, 1'b0, 10'd3, -1);
        chk("s3_sel_at1", sel_at1, 1);
        chk("s3_busy_at1", busy_at1, 1);
        chk("s3_ready_at1", ready_at1, 0);
        chk("s3_first_rise", first_rise, 3);
        chk("s3_pulses", pulses, 3);
        chk("s3_hi_width_bad", hi_bad, 0);
        chk("s3_lo_gap_bad", lo_bad, 0);
        chk("s3_done_cyc", done_cyc, 15);
        chk("s3_err_cyc", err_cyc, -1);
        chk("s3_loads", lpulses, 0);
        chk("s3_phase1", ph(1), 3);
        chk("s3_ready_after", req_ready, 1);
        chk("s3_busy_after", busy, 0);

        // sel=2, -2 steps from 0 wraps to 6, then +3 wraps to 1
        run_req(1'b0, 2'd2, 1'b1, 10'd2, -1);
        chk("dn2_dir_at1", dir_at1, 1);
        chk("dn2_done_cyc", done_cyc, 11);
        chk("dn2_phase2", ph(2), 6);
        tick();
        run_req(1'b0, 2'd2, 1'b0, 10'd3, -1);
        chk("up3_done_cyc", done_cyc, 15);
        chk("up3_phase2", ph(2), 1);

        // sel=3: two steps, then static reload
        tick();
        run_req(1'b0, 2'd3, 1'b0, 10'd2, -1);
        chk("pre_load_phase3", ph(3), 2);
        tick();
        run_req(1'b1, 2'd3, 1'b0, 10'd4, -1);
        chk("load_loads", lpulses, 1);
        chk("load_steps", pulses, 0);
        chk("load_both_hi", both_hi, 0);
        chk("load_done_cyc", done_cyc, 7);
        chk("load_phase3", ph(3), 0);
        chk("load_others", {ph(1), ph(2)}, {10'd3, 10'd1});

        // zero steps
        tick();
        run_req(1'b0, 2'd0, 1'b0, 10'd0, -1);
        chk("z_pulses", pulses, 0);
        chk("z_done_cyc", done_cyc, 3);
        chk("z_phase0", ph(0), 0);

        // lock loss during 2nd high pulse (cycles 7..8)
        tick();
        run_req(1'b0, 2'd0, 1'b0, 10'd5, 7);
        chk("ll_pulses", pulses, 2);
        chk("ll_hi_width_bad", hi_bad, 0);
        chk("ll_err_cyc", err_cyc, 9);
        chk("ll_done_cyc", done_cyc, -1);
        chk("ll_phase0", ph(0), 2);
        chk("ll_ready_unlocked", req_ready, 0);
        chk("ll_busy", busy, 0);
        chk("ll_no_done", done, 0);
        locked_i = 1'b1;
        tick();
        chk("ll_ready_relock", req_ready, 1);

        // async reset in the middle of a high pulse
        req_valid = 1'b1; req_load = 1'b0; req_sel = 2'd1; req_dir = 1'b0; req_steps = 10'd4;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk("ar_step_hi", phasestep, 1);
        #2 reset_n = 1'b0;
        locked_i = 1'b0;
        #1;
        chk("ar_step_low", phasestep, 0);
        chk("ar_phase", phase_o, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_ready_unlocked", req_ready, 0);
        locked_i = 1'b1;
        #1;
        chk("ar_ready_locked", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
